// File: rtl/dr32e_branch_resolve.sv
// Execute-side branch resolution: pops fetch prediction records in order, compares predicted vs actual next-PC, issues a registered redirect.
// Optional performance counters are enabled by defining DR32E_BRANCH_RESOLVE_PERF_EN.
module dr32e_branch_resolve #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pred_valid_i,
  output logic        pred_ready_o,
  input  logic [31:0] pred_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  input  logic        res_valid_i,
  input  logic [31:0] res_pc_i,
  input  logic        res_compressed_i,
  input  logic        res_is_branch_i,
  input  logic        res_taken_i,
  input  logic [31:0] res_target_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        underflow_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [0:0] {ST_RUN, ST_REDIR} state_t;

  state_t           state_q, state_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             underflow_q, underflow_d;

  logic [31:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic        ready;
  logic        push;
  logic        pop;
  logic        res_accept;
  logic        issue_redir;
  logic [31:0] len;
  logic [31:0] head_pc;
  logic        head_taken;
  logic [31:0] head_target;
  logic [31:0] pred_next;
  logic [31:0] act_next;
  logic        mispredict;

  assign head_pc     = pc_mem[rd_ptr_q];
  assign head_taken  = taken_mem[rd_ptr_q];
  assign head_target = target_mem[rd_ptr_q];

  always_comb begin
    len        = res_compressed_i ? 32'd2 : 32'd4;
    pred_next  = head_taken ? head_target : head_pc + len;
    act_next   = res_taken_i ? res_target_i : res_pc_i + len;
    // A PC mismatch means fetch and execute disagree on the stream; resync via redirect.
    mispredict = (pred_next != act_next) || (head_pc != res_pc_i);
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    underflow_d   = underflow_q;
    ready         = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    res_accept    = 1'b0;
    issue_redir   = 1'b0;

    case (state_q)
      ST_RUN: begin
        ready      = (count_q != CNT_FULL);
        push       = pred_valid_i && ready;
        res_accept = res_valid_i;
        if (res_valid_i && (count_q != '0)) begin
          pop         = 1'b1;
          issue_redir = mispredict;
        end else if (res_valid_i) begin
          underflow_d = 1'b1;
          issue_redir = res_taken_i;
        end

        if (issue_redir) begin
          // Flush drops everything, including a record pushed this same cycle.
          state_d       = ST_REDIR;
          count_d       = '0;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          redirect_d    = 1'b1;
          redirect_pc_d = act_next;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
      end
      ST_REDIR: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      underflow_q   <= underflow_d;
    end
  end

  // Record storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]     <= pred_pc_i;
      taken_mem[wr_ptr_q]  <= pred_taken_i;
      target_mem[wr_ptr_q] <= pred_target_i;
    end
  end

  assign pred_ready_o  = ready;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign underflow_o   = underflow_q;

`ifdef DR32E_BRANCH_RESOLVE_PERF_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (res_accept && res_is_branch_i && (branch_cnt_q != 32'hFFFF_FFFF))
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (issue_redir && (mispredict_cnt_q != 32'hFFFF_FFFF))
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  logic unused_perf;
  assign unused_perf      = res_is_branch_i ^ res_accept;
  assign branch_cnt_o     = 32'd0;
  assign mispredict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dr32e_branch_resolve.sv
// Directed bench for dr32e_branch_resolve; counter expectations follow DR32E_BRANCH_RESOLVE_PERF_EN.
module tb_dr32e_branch_resolve;

`ifdef DR32E_BRANCH_RESOLVE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pred_valid_i;
  logic        pred_ready_o;
  logic [31:0] pred_pc_i;
  logic        pred_taken_i;
  logic [31:0] pred_target_i;
  logic        res_valid_i;
  logic [31:0] res_pc_i;
  logic        res_compressed_i;
  logic        res_is_branch_i;
  logic        res_taken_i;
  logic [31:0] res_target_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        underflow_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  dr32e_branch_resolve #(.DEPTH(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pred_valid_i     (pred_valid_i),
    .pred_ready_o     (pred_ready_o),
    .pred_pc_i        (pred_pc_i),
    .pred_taken_i     (pred_taken_i),
    .pred_target_i    (pred_target_i),
    .res_valid_i      (res_valid_i),
    .res_pc_i         (res_pc_i),
    .res_compressed_i (res_compressed_i),
    .res_is_branch_i  (res_is_branch_i),
    .res_taken_i      (res_taken_i),
    .res_target_i     (res_target_i),
    .redirect_o       (redirect_o),
    .redirect_pc_o    (redirect_pc_o),
    .underflow_o      (underflow_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    pred_valid_i     = 1'b0;
    pred_pc_i        = '0;
    pred_taken_i     = 1'b0;
    pred_target_i    = '0;
    res_valid_i      = 1'b0;
    res_pc_i         = '0;
    res_compressed_i = 1'b0;
    res_is_branch_i  = 1'b0;
    res_taken_i      = 1'b0;
    res_target_i     = '0;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    idle();
    pred_valid_i = 1'b1; pred_pc_i = pc; pred_taken_i = tk; pred_target_i = tgt;
    tick();
    idle();
  endtask

  task automatic set_res(input logic [31:0] pc, input logic comp, input logic tk, input logic [31:0] tgt);
    res_valid_i = 1'b1; res_pc_i = pc; res_compressed_i = comp;
    res_is_branch_i = 1'b1; res_taken_i = tk; res_target_i = tgt;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    n_vec++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL reset_redirect got=%0b exp=0", redirect_o); end
    n_vec++; if (redirect_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc_o); end
    n_vec++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL reset_underflow got=%0b exp=0", underflow_o); end
    n_vec++; if (pred_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b exp=1", pred_ready_o); end
    n_vec++; if (branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin
      n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", branch_cnt_o, mispredict_cnt_o); end
    $display("reset: ready=%0b redirect=%0b", pred_ready_o, redirect_o);
  endtask

  task automatic test_correct();
    push(32'h100, 1'b1, 32'h80);
    set_res(32'h100, 1'b0, 1'b1, 32'h80);
    tick(); idle();
    n_vec++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL correct_redirect got=%0b exp=0", redirect_o); end
    n_vec++; if (branch_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin
      n_err++; $display("FAIL correct_branch_cnt got=%0d exp=%0d", branch_cnt_o, PERF ? 1 : 0); end
    $display("correct: pc=0x100 redirect=%0b branch_cnt=%0d", redirect_o, branch_cnt_o);
  endtask

  task automatic test_dir_mispredict();
    push(32'h200, 1'b1, 32'h1F0);
    set_res(32'h200, 1'b0, 1'b0, 32'h0);
    tick();
    // REDIR cycle: a stray resolution with an empty queue must be ignored.
    set_res(32'h0, 1'b0, 1'b1, 32'hDEAD_0000);
    n_vec++; if (redirect_o !== 1'b1) begin n_err++; $display("FAIL dir_redirect got=%0b exp=1", redirect_o); end
    n_vec++; if (redirect_pc_o !== 32'h204) begin n_err++; $display("FAIL dir_redirect_pc got=%h exp=00000204", redirect_pc_o); end
    n_vec++; if (pred_ready_o !== 1'b0) begin n_err++; $display("FAIL dir_ready_in_redir got=%0b exp=0", pred_ready_o); end
    n_vec++; if (mispredict_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin
      n_err++; $display("FAIL dir_mis_cnt got=%0d exp=%0d", mispredict_cnt_o, PERF ? 1 : 0); end
    tick(); idle();
    n_vec++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL dir_pulse_width got=%0b exp=0", redirect_o); end
    n_vec++; if (redirect_pc_o !== 32'h204) begin n_err++; $display("FAIL dir_pc_hold got=%h exp=00000204", redirect_pc_o); end
    n_vec++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL dir_redir_ignores_res got=%0b exp=0", underflow_o); end
    n_vec++; if (pred_ready_o !== 1'b1) begin n_err++; $display("FAIL dir_ready_after got=%0b exp=1", pred_ready_o); end
    $display("dir_mispredict: redirect_pc=%h", redirect_pc_o);
  endtask

  task automatic test_compressed();
    push(32'h300, 1'b0, 32'h0);
    set_res(32'h300, 1'b1, 1'b1, 32'h340);
    tick(); idle();
    n_vec++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h340) begin
      n_err++; $display("FAIL comp_target got=%0b/%h exp=1/00000340", redirect_o, redirect_pc_o); end
    tick();
    push(32'h300, 1'b0, 32'h0);
    set_res(32'h300, 1'b1, 1'b0, 32'h0);
    tick(); idle();
    n_vec++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL comp_fallthrough got=%0b exp=0", redirect_o); end
    $display("compressed: target redirect and 0x302 fall-through done");
  endtask

  task automatic test_full();
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      push(32'h400 + 32'(4*i), 1'b0, 32'h0);
      n_vec++; if (pred_ready_o !== exp_rdy[i]) begin
        n_err++; $display("FAIL full_ready_%0d got=%0b exp=%0b", i, pred_ready_o, exp_rdy[i]); end
    end
    pred_valid_i = 1'b1; pred_pc_i = 32'h999; pred_taken_i = 1'b0; pred_target_i = '0;
    set_res(32'h400, 1'b0, 1'b0, 32'h0);
    #1;
    n_vec++; if (pred_ready_o !== 1'b0) begin n_err++; $display("FAIL full_no_bypass got=%0b exp=0", pred_ready_o); end
    tick(); idle();
    n_vec++; if (redirect_o !== 1'b0 || pred_ready_o !== 1'b1) begin
      n_err++; $display("FAIL full_pop got=%0b/%0b exp=0/1", redirect_o, pred_ready_o); end
    push(32'h410, 1'b0, 32'h0);
    n_vec++; if (pred_ready_o !== 1'b0) begin n_err++; $display("FAIL full_count3 got=%0b exp=0", pred_ready_o); end
    for (int i = 1; i < 5; i++) begin
      set_res(32'h400 + 32'(4*i), 1'b0, 1'b0, 32'h0);
      tick(); idle();
      n_vec++; if (redirect_o !== 1'b0) begin
        n_err++; $display("FAIL full_drain_%0d got=%0b exp=0", i, redirect_o); end
    end
    $display("full: drained 0x404..0x410 in order");
  endtask

  task automatic test_flush();
    push(32'h600, 1'b0, 32'h0);
    push(32'h604, 1'b0, 32'h0);
    push(32'h608, 1'b0, 32'h0);
    pred_valid_i = 1'b1; pred_pc_i = 32'h500; pred_taken_i = 1'b0; pred_target_i = '0;
    set_res(32'h600, 1'b0, 1'b1, 32'h700);
    tick(); idle();
    n_vec++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h700) begin
      n_err++; $display("FAIL flush_redirect got=%0b/%h exp=1/00000700", redirect_o, redirect_pc_o); end
    tick();
    n_vec++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL flush_pre_underflow got=%0b exp=0", underflow_o); end
    set_res(32'h500, 1'b0, 1'b0, 32'h0);
    tick(); idle();
    n_vec++; if (underflow_o !== 1'b1 || redirect_o !== 1'b0) begin
      n_err++; $display("FAIL flush_underflow got=%0b/%0b exp=1/0", underflow_o, redirect_o); end
    set_res(32'h0, 1'b0, 1'b1, 32'h800);
    tick(); idle();
    n_vec++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h800) begin
      n_err++; $display("FAIL underflow_taken got=%0b/%h exp=1/00000800", redirect_o, redirect_pc_o); end
    tick();
    $display("flush: underflow=%0b", underflow_o);
  endtask

  task automatic test_wrap_reset();
    push(32'hFFFF_FFFC, 1'b0, 32'h0);
    set_res(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    tick(); idle();
    n_vec++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL wrap_redirect got=%0b exp=0", redirect_o); end
    push(32'h10, 1'b1, 32'h20);
    set_res(32'h10, 1'b0, 1'b0, 32'h0);
    tick(); idle();
    n_vec++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h14) begin
      n_err++; $display("FAIL wrap_pre_reset got=%0b/%h exp=1/00000014", redirect_o, redirect_pc_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_vec++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0 || underflow_o !== 1'b0) begin
      n_err++; $display("FAIL redir_reset got=%0b/%h/%0b exp=0/00000000/0", redirect_o, redirect_pc_o, underflow_o); end
    n_vec++; if (pred_ready_o !== 1'b1 || branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin
      n_err++; $display("FAIL redir_reset_misc got=%0b/%0d/%0d exp=1/0/0", pred_ready_o, branch_cnt_o, mispredict_cnt_o); end
    tick();
    n_vec++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL no_redirect_after_reset got=%0b exp=0", redirect_o); end
    $display("wrap_reset: redirect=%0b redirect_pc=%h", redirect_o, redirect_pc_o);
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    test_reset();
    test_correct();
    test_dir_mispredict();
    test_compressed();
    test_full();
    test_flush();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
